// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and framing constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  localparam int UART_DATA_W = 8;
  localparam int UART_STOP_BITS = 1;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with separate level tracking so full and empty are distinct
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter with back-to-back framing
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT-1);
  tx_state_e state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift, head;
  logic full, empty, pop, bit_end, stop_end;
  assign bit_end = cnt == CMAX;
  assign stop_end = state == STOP && bit_end && bit_idx == '0;
  assign pop = !empty && (state == IDLE || stop_end);
  assign in_ready = !full;
  assign busy = state != IDLE || fifo_level != '0;
  sync_fifo #(.DATA_W(UART_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid),
    .pop(pop),
    .wdata(in_data),
    .rdata(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
    end else if (pop) begin
      state <= START;
      tx <= 1'b0;
      cnt <= '0;
      shift <= head;
    end else if (state != IDLE) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
      if (bit_end && state == START) begin
        state <= DATA;
        bit_idx <= '0;
        tx <= shift[0];
      end else if (bit_end && state == DATA) begin
        state <= bit_idx == 3'(UART_DATA_W-1) ? STOP : DATA;
        tx <= bit_idx == 3'(UART_DATA_W-1) ? 1'b1 : shift[1];
        bit_idx <= bit_idx == 3'(UART_DATA_W-1) ? 3'(UART_STOP_BITS-1) : bit_idx + 1'b1;
        shift <= shift >> 1;
      end else if (bit_end && state == STOP) begin
        state <= bit_idx == '0 ? IDLE : STOP;
        bit_idx <= bit_idx == '0 ? bit_idx : bit_idx - 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed checks of framing, buffering, back-pressure and reset
module tb_uart_tx_buffered;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] in_data = '0;
  logic [2:0] vld = '0;
  wire [2:0] rdy, txs, bsy;
  wire [2:0] lvl4, lvl2, lvl87;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[0]), .in_ready(rdy[0]),
    .tx(txs[0]), .busy(bsy[0]), .fifo_level(lvl4));
  uart_tx_buffered #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[1]), .in_ready(rdy[1]),
    .tx(txs[1]), .busy(bsy[1]), .fifo_level(lvl2));
  uart_tx_buffered #(.CLKS_PER_BIT(87), .FIFO_DEPTH(4)) u87 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[2]), .in_ready(rdy[2]),
    .tx(txs[2]), .busy(bsy[2]), .fifo_level(lvl87));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input int s, input logic [7:0] d);
    int n = 0;
    in_data = d;
    vld[s] = 1'b1;
    while (!rdy[s] && n < 2000) begin
      step();
      n++;
    end
    check("push_wait", 32'(n < 2000), 1);
    step();
    vld[s] = 1'b0;
  endtask
  task automatic rx_byte(input int s, input int c, output logic [7:0] b, output int t);
    int n = 0;
    while (txs[s] !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("rx_start", 32'(n < 5000), 1);
    t = cyc;
    repeat (c/2) @(negedge clk);
    check("rx_startbit", 32'(txs[s]), 0);
    for (int j = 0; j < 8; j++) begin
      repeat (c) @(negedge clk);
      b[j] = txs[s];
    end
    repeat (c) @(negedge clk);
    check("rx_stop", 32'(txs[s]), 1);
  endtask
  initial begin
    logic [7:0] a5, b;
    logic [7:0] seq [6];
    logic [7:0] rnd [32];
    int k0, t, tp, n, zeros;
    a5 = 8'hA5;
    seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
    step(3);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) check("idle", {txs[0], rdy[0], bsy[0], lvl4}, 6'b110000);
    push(0, a5);
    check("latency_level", 32'(lvl4), 1);
    check("latency_tx", 32'(txs[0]), 1);
    for (int i = 0; i < 40; i++) begin
      step();
      check("a5_bit", 32'(txs[0]), 32'(i < 4 ? 1'b0 : i < 36 ? a5[(i-4)/4] : 1'b1));
    end
    check("busy_k40", 32'(bsy[0]), 1);
    step();
    check("busy_k41", 32'(bsy[0]), 0);
    check("tx_k41", 32'(txs[0]), 1);
    step(5);
    fork
      begin
        push(0, 8'h00);
        k0 = cyc;
        for (int i = 1; i < 5; i++) push(0, 8'(i));
        check("full_level", 32'(lvl4), 4);
        check("full_ready", 32'(rdy[0]), 0);
        in_data = 8'hFF;
        vld[0] = 1'b1;
        n = 0;
        while (lvl4 == 3'd4 && n < 100) begin
          step();
          n++;
        end
        check("pop_edge", 32'(cyc - k0), 41);
        check("pop_level", 32'(lvl4), 3);
        check("pop_ready", 32'(rdy[0]), 1);
        step();
        check("late_push_level", 32'(lvl4), 4);
        vld[0] = 1'b0;
      end
      begin
        tp = 0;
        for (int i = 0; i < 6; i++) begin
          rx_byte(0, 4, b, t);
          check("seq_byte", 32'(b), 32'(seq[i]));
          if (i > 0) check("seq_gap", 32'(t - tp), 40);
          tp = t;
        end
      end
    join
    n = 0;
    while (bsy[0] && n < 200) begin
      step();
      n++;
    end
    check("seq_drain", 32'(bsy[0]), 0);
    step(3);
    push(0, 8'h3C);
    push(0, 8'h11);
    push(0, 8'h22);
    step(10);
    check("pre_rst_level", 32'(lvl4), 2);
    rst = 1'b1;
    step();
    check("rst_tx", 32'(txs[0]), 1);
    check("rst_level", 32'(lvl4), 0);
    check("rst_busy", 32'(bsy[0]), 0);
    check("rst_ready", 32'(rdy[0]), 1);
    rst = 1'b0;
    zeros = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      zeros += int'(!txs[0]);
    end
    check("rst_no_frame", 32'(zeros), 0);
    for (int s = 1; s < 3; s++) begin
      for (int i = 0; i < 32; i++) rnd[i] = 8'($urandom);
      fork
        for (int i = 0; i < 32; i++) push(s, rnd[i]);
        for (int i = 0; i < 32; i++) begin
          rx_byte(s, s == 1 ? 2 : 87, b, t);
          check(s == 1 ? "rand_c2" : "rand_c87", 32'(b), 32'(rnd[i]));
        end
      join
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
